// File: rtl/exu_alu_pipe.sv
// Single-issue ALU stage with a valid/ready request side and a held, registered result.
// Define ALU_SERIAL_SHIFT_EN for a one-bit-per-cycle shifter instead of the barrel shifter.
module exu_alu_pipe #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [9:0]      op_i,
   input  logic            flush_i,
   output logic            res_valid_o,
   input  logic            res_ready_i,
   output logic [XLEN-1:0] res_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t             state;
   logic [XLEN-1:0]    res_q;
   logic [XLEN-1:0]    alu_res;
   logic [XLEN-1:0]    sll_res;
   logic [XLEN-1:0]    srl_res;
   logic [XLEN-1:0]    sra_res;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;

   assign shamt       = op2_i[SHAMT_W-1:0];
   assign req_ready_o = (state == IDLE) | ((state == HOLD) & res_ready_i);
   assign accept      = req_valid_i & req_ready_o;
   assign res_valid_o = (state == HOLD);
   assign busy_o      = (state != IDLE);
   assign res_o       = res_q;

`ifdef ALU_SERIAL_SHIFT_EN
   typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

   shift_kind_t        shift_kind_d;
   shift_kind_t        shift_kind_q;
   logic               is_shift;
   logic [SHAMT_W-1:0] shift_cnt;

   // Only a zero-distance shift completes through the ALU path; nonzero ones go serial
   assign sll_res = op1_i;
   assign srl_res = op1_i;
   assign sra_res = op1_i;

   always_comb begin
      is_shift     = 1'b0;
      shift_kind_d = SK_SLL;
      if (op_i[1:0] == 2'b00 && op_i[2]) begin
         is_shift = 1'b1;
      end else if (op_i[5:0] == 6'b0 && op_i[6]) begin
         is_shift     = 1'b1;
         shift_kind_d = SK_SRL;
      end else if (op_i[6:0] == 7'b0 && op_i[7]) begin
         is_shift     = 1'b1;
         shift_kind_d = SK_SRA;
      end
   end
`else
   assign sll_res = op1_i << shamt;
   assign srl_res = op1_i >> shamt;
   assign sra_res = $unsigned($signed(op1_i) >>> shamt);
`endif

   // Lowest set opcode bit wins; an empty opcode yields zero
   always_comb begin
      alu_res = '0;
      if (op_i[0])      alu_res = op1_i + op2_i;
      else if (op_i[1]) alu_res = op1_i - op2_i;
      else if (op_i[2]) alu_res = sll_res;
      else if (op_i[3]) alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      else if (op_i[4]) alu_res = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
      else if (op_i[5]) alu_res = op1_i ^ op2_i;
      else if (op_i[6]) alu_res = srl_res;
      else if (op_i[7]) alu_res = sra_res;
      else if (op_i[8]) alu_res = op1_i | op2_i;
      else if (op_i[9]) alu_res = op1_i & op2_i;
   end

   // Flush beats both a same-cycle accept and a result handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         res_q <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
         shift_cnt    <= '0;
         shift_kind_q <= SK_SLL;
`endif
      end else if (flush_i) begin
         state <= IDLE;
`ifdef ALU_SERIAL_SHIFT_EN
         shift_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
`ifdef ALU_SERIAL_SHIFT_EN
                  if (is_shift && shamt != '0) begin
                     state        <= SHIFT;
                     res_q        <= op1_i;
                     shift_cnt    <= shamt;
                     shift_kind_q <= shift_kind_d;
                  end else begin
                     state <= HOLD;
                     res_q <= alu_res;
                  end
`else
                  state <= HOLD;
                  res_q <= alu_res;
`endif
               end else if (state == HOLD && res_ready_i) begin
                  state <= IDLE;
               end
            end
`ifdef ALU_SERIAL_SHIFT_EN
            SHIFT: begin
               case (shift_kind_q)
                  SK_SLL:  res_q <= {res_q[XLEN-2:0], 1'b0};
                  SK_SRL:  res_q <= {1'b0, res_q[XLEN-1:1]};
                  default: res_q <= {res_q[XLEN-1], res_q[XLEN-1:1]};
               endcase
               shift_cnt <= shift_cnt - SHAMT_W'(1);
               if (shift_cnt == SHAMT_W'(1)) state <= HOLD;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
